divider: RTL and testbench
==========================

# divider

Iterative RV32M divide unit executing DIV, DIVU, REM and REMU. It sits beside the two-stage multiplier in the execute stage and takes the same decoded operand bundle. It computes one quotient bit per cycle with a restoring radix-2 algorithm. It raises `busy` so the pipeline stalls while an operation is in flight, then presents a registered result with `wb_valid` for one cycle.

## Interface
- `XLEN`, 32: operand width; only 32 is supported.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `valid`  in  1  execute-stage instruction valid.
- `opcode`  in  32  full instruction word.
- `rd_idx`  in  5  destination register index.
- `ra_operand`  in  32  dividend (rs1 value).
- `rb_operand`  in  32  divisor (rs2 value).
- `hold`  in  1  global pipeline freeze; all state holds while high.
- `busy`  out  1  operation in flight; the pipeline must stall and hold inputs stable.
- `wb_valid`  out  1  `wb_value` / `wb_rd_idx` are valid this cycle.
- `wb_value`  out  32  quotient or remainder.
- `wb_rd_idx`  out  5  destination index captured at accept.

## Operation
- Decode: an instruction is a div instruction when `(opcode & IM__DIV) == I__{DIV,DIVU,REM,REMU}`.
  - IM__DIV = 0xFE00707F.
  - I__DIV = 0x02004033, I__DIVU = 0x02005033, I__REM = 0x02006033, I__REMU = 0x02007033.
- Accept when `valid & div_inst & ~hold` and state is IDLE or DONE.
  - Latch signedness, the rem/quotient select, and `rd_idx`.
  - Latch |a| and |b| (signed ops) or raw operands (unsigned ops).
  - Latch neg_q = sa^sb and neg_r = sa (both 0 for unsigned ops).
- Special cases resolve at accept and go straight to DONE:
  - b==0: quotient 0xFFFFFFFF, remainder = a.
  - Signed a==0x80000000 with b==0xFFFFFFFF: quotient 0x80000000, remainder 0.
- States:
  - IDLE → CALC on a normal accept; count=0, remainder=0.
  - CALC: shift {rem,quo} left 1, trial-subtract the divisor, restore if negative. `count` increments; when `count==31`, go to FIX.
  - FIX: apply the signs (two's complement when neg_q / neg_r), select quotient or remainder into `wb_value`, go to DONE.
  - DONE: `wb_valid`=1. A new accept goes to CALC (or DONE for a special case); otherwise go to IDLE.
- Arithmetic: the remainder/trial register is 33 bits; quotient, divisor and magnitudes are 32 bits. |0x80000000| is 0x80000000 unsigned, which is correct.
- `busy` = state ∈ {CALC, FIX}, decoded from registered state, so it is glitch-free.
- `valid` with a non-div opcode is ignored. `valid` while busy is ignored because the stall guarantees it is the same instruction.
- `wb_value` and `wb_rd_idx` hold their last value outside DONE.
- Reset, including mid-operation: state IDLE, `busy`=0, `wb_valid`=0, `wb_value`=0, `wb_rd_idx`=0, count=0. Any partial result is discarded.

## Timing
- Accept edge E0. CALC iterations occur on edges E1..E32. FIX registers the result at E33.
- Normal op: `wb_valid` is high in the cycle after E33, for 33 cycles of latency. `busy` is high in cycles E0+ through E32+.
- Special case: `wb_valid` is high in the cycle after E0, with `busy` never high.
- `hold` high freezes state, count, datapath and outputs. In DONE, `wb_valid` stays high for every held cycle plus one.
- Back-to-back: an accept in the DONE cycle starts the next op with no idle bubble.

## Structure
- `defs.v` gets IM__DIV and the four I__DIV/DIVU/REM/REMU constants, plus the state encodings DIV_IDLE, DIV_CALC, DIV_FIX, DIV_DONE (2 bits).
- One sub-module: `div_step`, the combinational shift/trial-subtract/restore for one bit. It takes the 33-bit rem, 32-bit quo and 32-bit divisor and returns next rem and next quo.
- The top level holds the FSM, the counter, the sign fixup and the output registers.

## Test plan
- DIVU 100/7 → after 33 cycles `wb_valid`=1, `wb_value`=14; REMU 100/7 → 2; `busy` high for exactly 33 cycles.
- DIV -7/2 → 0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1); REM 7/-2 → 1.
- DIV and REM of 0x80000000 / 0xFFFFFFFF → 0x80000000 and 0 one cycle after accept, `busy` never high. DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
- Assert `hold` for 5 cycles mid-CALC → result and latency both shift by exactly 5 cycles. `hold` during DONE → `wb_valid` is extended.
- Assert `rst` at CALC count=10 → all outputs 0 immediately. A new DIVU 9/3 then returns 3 with `wb_rd_idx` taken from the new op.
- Non-div opcode (MUL 0x02000033) with `valid` → no `busy`, no `wb_valid`. Back-to-back DIVU ops → the second accepts in the DONE cycle and `wb_value` updates correctly.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared decode constants, state encodings and the div-instruction decode helper
// for the iterative RV32M divide unit.
package divider_pkg;

  localparam logic [31:0] IM__DIV  = 32'hFE00707F;
  localparam logic [31:0] I__DIV   = 32'h02004033;
  localparam logic [31:0] I__DIVU  = 32'h02005033;
  localparam logic [31:0] I__REM   = 32'h02006033;
  localparam logic [31:0] I__REMU  = 32'h02007033;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_FIX  = 2'd2;
  localparam logic [1:0] DIV_DONE = 2'd3;

  function automatic logic is_div_inst(input logic [31:0] op);
    logic [31:0] masked;
    masked = op & IM__DIV;
    return (masked == I__DIV) || (masked == I__DIVU) ||
           (masked == I__REM) || (masked == I__REMU);
  endfunction

endpackage

// File: rtl/divider_div_step.sv
// One restoring radix-2 iteration: shift {rem,quo} left, trial-subtract the
// divisor, keep the difference and set the quotient bit only if it is non-negative.
module div_step (
  input  logic [32:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] divisor_i,
  output logic [32:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted;
  logic [32:0] trial;
  logic        fits;

  always_comb begin
    shifted = {rem_i[31:0], quo_i[31]};
    // rem_i[32] set would mean the shifted value exceeds 33 bits, so it always fits
    fits    = rem_i[32] | (shifted >= {1'b0, divisor_i});
    trial   = shifted - {1'b0, divisor_i};
    rem_o   = fits ? trial : shifted;
    quo_o   = {quo_i[30:0], fits};
  end

endmodule

// File: rtl/divider.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: FSM, iteration counter, sign fixup and
// registered writeback; one quotient bit per cycle via div_step.
module divider
  import divider_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [31:0]     opcode,
  input  logic [4:0]      rd_idx,
  input  logic [XLEN-1:0] ra_operand,
  input  logic [XLEN-1:0] rb_operand,
  input  logic            hold,
  output logic            busy,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_value,
  output logic [4:0]      wb_rd_idx
);

  logic [1:0]      state_q, state_d;
  logic [4:0]      count_q, count_d;
  logic [32:0]     rem_q, rem_d;
  logic [31:0]     quo_q, quo_d;
  logic [31:0]     dvs_q, dvs_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            sel_rem_q, sel_rem_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] wb_value_q, wb_value_d;
  logic [4:0]      wb_rd_idx_q, wb_rd_idx_d;

  logic [32:0] step_rem;
  logic [31:0] step_quo;

  logic        accept;
  logic        op_signed, op_rem;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_by_zero, overflow;
  logic [31:0] q_fixed, r_fixed;

  div_step u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    sel_rem_d   = sel_rem_q;
    rd_d        = rd_q;
    wb_value_d  = wb_value_q;
    wb_rd_idx_d = wb_rd_idx_q;

    accept      = valid & is_div_inst(opcode) & ~hold &
                  ((state_q == DIV_IDLE) || (state_q == DIV_DONE));
    op_signed   = ~opcode[12];
    op_rem      = opcode[13];
    a_neg       = op_signed & ra_operand[31];
    b_neg       = op_signed & rb_operand[31];
    a_mag       = a_neg ? -ra_operand : ra_operand;
    b_mag       = b_neg ? -rb_operand : rb_operand;
    div_by_zero = (rb_operand == '0);
    overflow    = op_signed && (ra_operand == 32'h8000_0000) && (rb_operand == '1);
    q_fixed     = q_neg_q ? -quo_q : quo_q;
    r_fixed     = r_neg_q ? -rem_q[31:0] : rem_q[31:0];

    if (!hold) begin
      case (state_q)
        DIV_IDLE, DIV_DONE: begin
          if (accept) begin
            sel_rem_d = op_rem;
            rd_d      = rd_idx;
            q_neg_d   = a_neg ^ b_neg;
            r_neg_d   = a_neg;
            if (div_by_zero) begin
              wb_value_d  = op_rem ? ra_operand : '1;
              wb_rd_idx_d = rd_idx;
              state_d     = DIV_DONE;
            end else if (overflow) begin
              wb_value_d  = op_rem ? '0 : ra_operand;
              wb_rd_idx_d = rd_idx;
              state_d     = DIV_DONE;
            end else begin
              count_d = '0;
              rem_d   = '0;
              quo_d   = a_mag;
              dvs_d   = b_mag;
              state_d = DIV_CALC;
            end
          end else begin
            state_d = DIV_IDLE;
          end
        end
        DIV_CALC: begin
          rem_d   = step_rem;
          quo_d   = step_quo;
          count_d = count_q + 5'd1;
          if (count_q == 5'd31) state_d = DIV_FIX;
        end
        default: begin
          wb_value_d  = sel_rem_q ? r_fixed : q_fixed;
          wb_rd_idx_d = rd_q;
          state_d     = DIV_DONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DIV_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      sel_rem_q   <= 1'b0;
      rd_q        <= '0;
      wb_value_q  <= '0;
      wb_rd_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      sel_rem_q   <= sel_rem_d;
      rd_q        <= rd_d;
      wb_value_q  <= wb_value_d;
      wb_rd_idx_q <= wb_rd_idx_d;
    end
  end

  assign busy      = (state_q == DIV_CALC) || (state_q == DIV_FIX);
  assign wb_valid  = (state_q == DIV_DONE);
  assign wb_value  = wb_value_q;
  assign wb_rd_idx = wb_rd_idx_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed RV32M cases plus random operations
// compared against an arithmetic reference model, including latency and busy span.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] opcode;
  logic [4:0]  rd_idx;
  logic [31:0] ra_operand, rb_operand;
  logic        hold;
  logic        busy, wb_valid;
  logic [31:0] wb_value;
  logic [4:0]  wb_rd_idx;

  int n_checks = 0;
  int n_fail   = 0;

  divider #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .opcode     (opcode),
    .rd_idx     (rd_idx),
    .ra_operand (ra_operand),
    .rb_operand (rb_operand),
    .hold       (hold),
    .busy       (busy),
    .wb_valid   (wb_valid),
    .wb_value   (wb_value),
    .wb_rd_idx  (wb_rd_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // f: 0=DIV 1=DIVU 2=REM 3=REMU
  function automatic logic [31:0] model(input int unsigned f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic   sgn;
    logic   want_rem;
    sgn      = (f == 0) || (f == 2);
    want_rem = (f >= 2);
    if (b == 0) return want_rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return want_rem ? 32'h0 : 32'h8000_0000;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return want_rem ? r[31:0] : q[31:0];
  endfunction

  function automatic int expected_latency(input int unsigned f, input logic [31:0] a,
                                          input logic [31:0] b);
    if (b == 0) return 0;
    if ((f == 0 || f == 2) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 33;
  endfunction

  // Random register fields outside the decode mask must not affect decode.
  function automatic logic [31:0] mk_op(input int unsigned f);
    return 32'h0200_4033 | (32'(f) << 12) | ($urandom & ~32'hFE00_707F);
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int unsigned f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    valid      = 1'b1;
    opcode     = mk_op(f);
    ra_operand = a;
    rb_operand = b;
    rd_idx     = rd;
    tick();
    valid      = 1'b0;
    rd_idx     = 5'($urandom);
  endtask

  task automatic collect(input string tag, input int unsigned f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input int hold_at, input int hold_len);
    int lat    = 0;
    int busy_n = 0;
    int exp_lat;
    exp_lat = expected_latency(f, a, b);
    if (exp_lat != 0) exp_lat += hold_len;
    while (!wb_valid && lat < 200) begin
      if (busy) busy_n++;
      if (hold_len > 0 && lat == hold_at) hold = 1'b1;
      if (hold_len > 0 && lat == hold_at + hold_len) hold = 1'b0;
      tick();
      lat++;
    end
    hold = 1'b0;
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/busy_cycles"}, 32'(busy_n), 32'(exp_lat));
    check({tag, "/value"}, wb_value, model(f, a, b));
    check({tag, "/rd"}, {27'h0, wb_rd_idx}, {27'h0, rd});
  endtask

  typedef struct {
    int unsigned f;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t dir_vecs[] = '{
    '{1, 32'd100, 32'd7},
    '{3, 32'd100, 32'd7},
    '{0, -32'sd7, 32'd2},
    '{2, -32'sd7, 32'd2},
    '{2, 32'd7, -32'sd2},
    '{0, 32'h8000_0000, 32'hFFFF_FFFF},
    '{2, 32'h8000_0000, 32'hFFFF_FFFF},
    '{1, 32'd5, 32'd0},
    '{2, 32'd5, 32'd0},
    '{0, 32'h8000_0000, 32'd1},
    '{3, 32'hFFFF_FFFF, 32'h8000_0000}
  };

  initial begin
    logic flag;
    logic [31:0] a, b;
    int unsigned f;
    logic [4:0] rd;

    rst = 1'b1; valid = 1'b0; hold = 1'b0; opcode = '0;
    rd_idx = '0; ra_operand = '0; rb_operand = '0;
    repeat (3) tick();
    check("reset/busy", {31'h0, busy}, 32'h0);
    check("reset/wb_valid", {31'h0, wb_valid}, 32'h0);
    check("reset/wb_value", wb_value, 32'h0);
    check("reset/wb_rd_idx", {27'h0, wb_rd_idx}, 32'h0);
    rst = 1'b0;
    tick();

    foreach (dir_vecs[i]) begin
      rd = 5'(i + 1);
      issue(dir_vecs[i].f, dir_vecs[i].a, dir_vecs[i].b, rd);
      collect($sformatf("dir%0d", i), dir_vecs[i].f, dir_vecs[i].a, dir_vecs[i].b, rd, 0, 0);
      tick();
      check("dir/wb_valid_drop", {31'h0, wb_valid}, 32'h0);
      check("dir/value_hold", wb_value, model(dir_vecs[i].f, dir_vecs[i].a, dir_vecs[i].b));
    end

    // hold for 5 cycles mid-CALC, then hold while in DONE
    issue(1, 32'd1000, 32'd13, 5'd9);
    collect("hold_calc", 1, 32'd1000, 32'd13, 5'd9, 10, 5);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_done/wb_valid", {31'h0, wb_valid}, 32'h1);
    end
    hold = 1'b0;
    check("hold_done/release_cycle", {31'h0, wb_valid}, 32'h1);
    tick();
    check("hold_done/drop", {31'h0, wb_valid}, 32'h0);
    check("hold_done/value_kept", wb_value, 32'd76);

    // reset mid-operation at count=10
    issue(1, 32'hFFFF_0000, 32'd3, 5'd12);
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check("midrst/busy", {31'h0, busy}, 32'h0);
    check("midrst/wb_valid", {31'h0, wb_valid}, 32'h0);
    check("midrst/wb_value", wb_value, 32'h0);
    check("midrst/wb_rd_idx", {27'h0, wb_rd_idx}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    issue(1, 32'd9, 32'd3, 5'd21);
    collect("after_rst", 1, 32'd9, 32'd3, 5'd21, 0, 0);
    tick();

    // non-div opcode must be ignored
    valid = 1'b1; opcode = 32'h0200_0033; ra_operand = 32'd8; rb_operand = 32'd2;
    tick();
    valid = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy || wb_valid) flag = 1'b1;
      tick();
    end
    check("mul_ignored", {31'h0, flag}, 32'h0);

    // back-to-back: second op accepted in the DONE cycle of the first
    issue(1, 32'd77, 32'd5, 5'd3);
    collect("b2b_first", 1, 32'd77, 32'd5, 5'd3, 0, 0);
    issue(3, 32'd77, 32'd5, 5'd4);
    collect("b2b_second", 3, 32'd77, 32'd5, 5'd4, 0, 0);
    issue(1, 32'd6, 32'd0, 5'd5);
    collect("b2b_special", 1, 32'd6, 32'd0, 5'd5, 0, 0);
    tick();

    for (int n = 0; n < 40; n++) begin
      f  = $urandom_range(0, 3);
      a  = rnd_operand();
      b  = rnd_operand();
      rd = 5'($urandom);
      issue(f, a, b, rd);
      collect($sformatf("rand%0d", n), f, a, b, rd, 0, 0);
      if ($urandom_range(0, 1) == 0) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
